// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: default board size, reveal FSM states and neighbor offsets.
package minesweeper_pkg;

    localparam int NUM_SQUARES_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2,
        DONE = 2'd3
    } reveal_state_t;

    localparam int NUM_DIRS = 8;

    // Neighbor walk order NW, N, NE, W, E, SW, S, SE; two's-complement -1/0/+1 offsets.
    localparam logic [1:0] DIR_ROW [NUM_DIRS] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    localparam logic [1:0] DIR_COL [NUM_DIRS] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};

endpackage

// File: rtl/reveal_queue.sv
// Synchronous FIFO of tile indices feeding the flood-fill walk; head is valid whenever not empty.
module reveal_queue #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign do_push = push && (count_reg != FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/reveal_ctrl.sv
// Reveal controller: sequences the neighbor-count unit and maintains the revealed bitmap.
// REVEAL_CTRL_FLOOD_EN enables zero-count flood expansion; without it only the start tile is revealed.
module reveal_ctrl
    import minesweeper_pkg::*;
#(
    parameter int NUM_SQUARES  = NUM_SQUARES_DEFAULT,
    parameter int INDEX_LENGTH = $clog2(NUM_SQUARES * NUM_SQUARES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [INDEX_LENGTH-1:0]            start_index,
    input  logic                               clear,
    input  logic [NUM_SQUARES*NUM_SQUARES-1:0] mine_map,
    output logic [INDEX_LENGTH-1:0]            nc_index,
    input  logic [3:0]                         nc_count,
    output logic                               cnt_we,
    output logic [INDEX_LENGTH-1:0]            cnt_addr,
    output logic [3:0]                         cnt_data,
    output logic [NUM_SQUARES*NUM_SQUARES-1:0] revealed,
    output logic                               busy,
    output logic                               done,
    output logic                               hit_mine
);
    localparam int NUM_TILES = NUM_SQUARES * NUM_SQUARES;
    localparam logic [INDEX_LENGTH:0] TILE_LIMIT = (INDEX_LENGTH + 1)'(NUM_TILES);

    reveal_state_t           state_reg;
    logic [NUM_TILES-1:0]    revealed_reg;
    logic                    hit_mine_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    cnt_we_reg;
    logic [INDEX_LENGTH-1:0] cnt_addr_reg;
    logic [3:0]              cnt_data_reg;

    logic                    start_in_range;
    logic                    start_revealed;
    logic                    start_mine;
    logic                    start_fill;
    logic [INDEX_LENGTH-1:0] pop_index;
    logic                    pop_valid;

    assign start_in_range = ({1'b0, start_index} < TILE_LIMIT);
    assign start_revealed = start_in_range && revealed_reg[start_index];
    assign start_mine     = start_in_range && mine_map[start_index];
    assign start_fill     = (state_reg == IDLE) && !clear && start && start_in_range
                            && !start_revealed && !start_mine;

`ifdef REVEAL_CTRL_FLOOD_EN
    localparam int CW = INDEX_LENGTH + 2;

    logic [2:0]              dir_reg;
    logic [INDEX_LENGTH-1:0] center_row_reg;
    logic [INDEX_LENGTH-1:0] center_col_reg;
    logic [INDEX_LENGTH-1:0] pop_row;
    logic [INDEX_LENGTH-1:0] pop_col;
    logic [CW-1:0]           nb_row;
    logic [CW-1:0]           nb_col;
    logic [INDEX_LENGTH-1:0] nb_index;
    logic                    nb_valid;
    logic                    nb_enq;
    logic                    q_push;
    logic                    q_pop;
    logic                    q_empty;
    logic [INDEX_LENGTH-1:0] q_push_data;
    logic [INDEX_LENGTH-1:0] q_head;

    assign pop_index = q_head;
    assign pop_valid = !q_empty;
    assign pop_row   = q_head / INDEX_LENGTH'(NUM_SQUARES);
    assign pop_col   = q_head % INDEX_LENGTH'(NUM_SQUARES);

    // A -1 step below row/col 0 wraps to a huge unsigned value, so one compare covers both edges.
    assign nb_row   = {2'b00, center_row_reg} + {{INDEX_LENGTH{DIR_ROW[dir_reg][1]}}, DIR_ROW[dir_reg]};
    assign nb_col   = {2'b00, center_col_reg} + {{INDEX_LENGTH{DIR_COL[dir_reg][1]}}, DIR_COL[dir_reg]};
    assign nb_valid = (nb_row < CW'(NUM_SQUARES)) && (nb_col < CW'(NUM_SQUARES));
    assign nb_index = nb_row[INDEX_LENGTH-1:0] * INDEX_LENGTH'(NUM_SQUARES) + nb_col[INDEX_LENGTH-1:0];
    assign nb_enq   = (state_reg == PUSH) && nb_valid && !revealed_reg[nb_index] && !mine_map[nb_index];

    assign q_push      = start_fill || nb_enq;
    assign q_push_data = (state_reg == PUSH) ? nb_index : start_index;
    assign q_pop       = (state_reg == POP) && !q_empty;

    reveal_queue #(
        .WIDTH(INDEX_LENGTH),
        .DEPTH(NUM_TILES)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_data(q_push_data),
        .pop      (q_pop),
        .head     (q_head),
        .empty    (q_empty)
    );
`else
    logic [INDEX_LENGTH-1:0] cur_index_reg;

    assign pop_index = cur_index_reg;
    assign pop_valid = 1'b1;
`endif

    // The count unit is combinational, so the index must be presented in the POP cycle itself.
    assign nc_index = ((state_reg == POP) && pop_valid) ? pop_index : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            revealed_reg   <= '0;
            hit_mine_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cnt_we_reg     <= 1'b0;
            cnt_addr_reg   <= '0;
            cnt_data_reg   <= '0;
`ifdef REVEAL_CTRL_FLOOD_EN
            dir_reg        <= '0;
            center_row_reg <= '0;
            center_col_reg <= '0;
`else
            cur_index_reg  <= '0;
`endif
        end else begin
            done_reg   <= 1'b0;
            cnt_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        revealed_reg <= '0;
                        hit_mine_reg <= 1'b0;
                    end else if (start) begin
                        busy_reg <= 1'b1;
                        if (!start_in_range || start_revealed) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else if (start_mine) begin
                            revealed_reg[start_index] <= 1'b1;
                            hit_mine_reg              <= 1'b1;
                            state_reg                 <= DONE;
                            done_reg                  <= 1'b1;
                        end else begin
                            revealed_reg[start_index] <= 1'b1;
`ifndef REVEAL_CTRL_FLOOD_EN
                            cur_index_reg             <= start_index;
`endif
                            state_reg                 <= POP;
                        end
                    end
                end
                POP: begin
                    if (pop_valid) begin
                        cnt_we_reg   <= 1'b1;
                        cnt_addr_reg <= pop_index;
                        cnt_data_reg <= nc_count;
`ifdef REVEAL_CTRL_FLOOD_EN
                        if (nc_count == 4'd0) begin
                            state_reg      <= PUSH;
                            dir_reg        <= '0;
                            center_row_reg <= pop_row;
                            center_col_reg <= pop_col;
                        end
`else
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                PUSH: begin
`ifdef REVEAL_CTRL_FLOOD_EN
                    if (nb_enq) begin
                        revealed_reg[nb_index] <= 1'b1;
                    end
                    dir_reg <= dir_reg + 3'd1;
                    if (dir_reg == 3'(NUM_DIRS - 1)) begin
                        state_reg <= POP;
                    end
`else
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign revealed = revealed_reg;
    assign hit_mine = hit_mine_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cnt_we   = cnt_we_reg;
    assign cnt_addr = cnt_addr_reg;
    assign cnt_data = cnt_data_reg;

endmodule

// File: tb/tb_reveal_ctrl.sv
// Scoreboard bench for reveal_ctrl: a reference reveal model queues expected count writes,
// which are popped and compared as the DUT strobes cnt_we.
module tb_reveal_ctrl;
    localparam int N = 5;
    localparam int T = N * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_index;
    logic        clear;
    logic [24:0] mine_map;
    logic [4:0]  nc_index;
    logic [3:0]  nc_count;
    logic        cnt_we;
    logic [4:0]  cnt_addr;
    logic [3:0]  cnt_data;
    logic [24:0] revealed;
    logic        busy;
    logic        done;
    logic        hit_mine;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]  exp_q[$];
    logic [24:0] exp_rev;
    logic        exp_hit;
    int          exp_lat;
    int          dr_tab[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int          dc_tab[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    reveal_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_index(start_index),
        .clear      (clear),
        .mine_map   (mine_map),
        .nc_index   (nc_index),
        .nc_count   (nc_count),
        .cnt_we     (cnt_we),
        .cnt_addr   (cnt_addr),
        .cnt_data   (cnt_data),
        .revealed   (revealed),
        .busy       (busy),
        .done       (done),
        .hit_mine   (hit_mine)
    );

    always #5 clk = ~clk;

    function automatic int mines_around(input logic [24:0] mm, input int idx);
        int r = idx / N;
        int c = idx % N;
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < N && c + dc >= 0 && c + dc < N) begin
                    if (mm[(r + dr) * N + c + dc]) n++;
                end
            end
        end
        return n;
    endfunction

    // Behaves as the external combinational neighbor-count unit.
    always_comb nc_count = 4'(mines_around(mine_map, int'(nc_index)));

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic model(input int s);
        int fq[$];
        int h, c, r, cc, nb;
        exp_lat = 1;
        if (s >= T) return;
        if (exp_rev[s]) return;
        if (mine_map[s]) begin
            exp_rev[s] = 1'b1;
            exp_hit    = 1'b1;
            return;
        end
        exp_rev[s] = 1'b1;
`ifdef REVEAL_CTRL_FLOOD_EN
        fq.push_back(s);
        while (fq.size() > 0) begin
            h = fq.pop_front();
            c = mines_around(mine_map, h);
            exp_q.push_back({5'(h), 4'(c)});
            exp_lat += 1;
            if (c == 0) begin
                exp_lat += 8;
                for (int d = 0; d < 8; d++) begin
                    r  = h / N + dr_tab[d];
                    cc = h % N + dc_tab[d];
                    if (r >= 0 && r < N && cc >= 0 && cc < N) begin
                        nb = r * N + cc;
                        if (!exp_rev[nb] && !mine_map[nb]) begin
                            exp_rev[nb] = 1'b1;
                            fq.push_back(nb);
                        end
                    end
                end
            end
        end
        exp_lat += 1;
`else
        exp_q.push_back({5'(s), 4'(mines_around(mine_map, s))});
        exp_lat += 1;
`endif
    endtask

    task automatic clear_board();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        exp_rev = '0;
        exp_hit = 1'b0;
        check("clear_revealed", int'(revealed), 0);
    endtask

    task automatic run_reveal(input int s, input int mid_start);
        int k = 1;
        int dones = 0;
        int done_k = 0;
        bit finished = 1'b0;
        logic [8:0] e;
        model(s);
        @(negedge clk);
        start       = 1'b1;
        start_index = 5'(s);
        @(negedge clk);
        start = 1'b0;
        while (!finished && k <= 400) begin
            if (k == 1) check("busy_run", int'(busy), 1);
            if (cnt_we) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", int'(cnt_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", int'(cnt_addr), int'(e[8:4]));
                    check("write_data", int'(cnt_data), int'(e[3:0]));
                end
            end
            if (done) begin
                dones++;
                done_k = k;
            end else if (dones > 0) begin
                finished = 1'b1;
            end
            if (k == 1 && mid_start >= 0) begin
                start       = 1'b1;
                start_index = 5'(mid_start);
            end else begin
                start = 1'b0;
            end
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        if (!finished) check("timeout", 0, 1);
        check("done_count", dones, 1);
        check("done_cycle", done_k, exp_lat);
        check("busy_after", int'(busy), 0);
        check("revealed", int'(revealed), int'(exp_rev));
        check("hit_mine", int'(hit_mine), int'(exp_hit));
        check("writes_left", exp_q.size(), 0);
        $display("reveal start=%0d revealed=%07h hit=%0d done_cycle=%0d", s, revealed, hit_mine, done_k);
        exp_q.delete();
    endtask

    initial begin
        int idle_act;
        rst         = 1'b1;
        start       = 1'b0;
        clear       = 1'b0;
        start_index = '0;
        mine_map    = '0;
        exp_rev     = '0;
        exp_hit     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_revealed", int'(revealed), 0);
        check("rst_hit", int'(hit_mine), 0);
        check("rst_we", int'(cnt_we), 0);
        check("rst_addr", int'(cnt_addr), 0);
        check("rst_data", int'(cnt_data), 0);
        check("rst_nc_index", int'(nc_index), 0);

        mine_map = '0;
        run_reveal(12, -1);

        clear_board();
        mine_map = 25'(1) << 12;
        run_reveal(12, -1);

        clear_board();
        mine_map = 25'd1;
        run_reveal(6, 20);

        clear_board();
        mine_map = 25'd1;
        run_reveal(24, -1);
        run_reveal(24, -1);
        run_reveal(30, -1);
        run_reveal(0, -1);

        // clear and start together in IDLE: clear must win and nothing starts
        @(negedge clk);
        clear       = 1'b1;
        start       = 1'b1;
        start_index = 5'd3;
        mine_map    = '0;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        exp_rev = '0;
        exp_hit = 1'b0;
        check("clr_start_busy", int'(busy), 0);
        check("clr_start_revealed", int'(revealed), 0);
        check("clr_start_hit", int'(hit_mine), 0);
        idle_act = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || cnt_we || busy) idle_act++;
        end
        check("clr_start_idle", idle_act, 0);
        $display("clear+start revealed=%07h busy=%0d", revealed, busy);

        // reset in the middle of a flood
        clear_board();
        mine_map = '0;
        @(negedge clk);
        start       = 1'b1;
        start_index = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_revealed", int'(revealed), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_we", int'(cnt_we), 0);
        idle_act = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || cnt_we) idle_act++;
        end
        check("midrst_quiet", idle_act, 0);
        $display("mid-flood reset revealed=%07h busy=%0d", revealed, busy);
        exp_rev = '0;
        exp_hit = 1'b0;

        for (int round = 0; round < 3; round++) begin
            clear_board();
            mine_map = '0;
            for (int j = 0; j < 3; j++) mine_map[$urandom_range(0, T - 1)] = 1'b1;
            run_reveal(int'($urandom_range(0, T - 1)), -1);
            run_reveal(int'($urandom_range(0, T - 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
